// File: rtl/processor_gen.sv
// ============================================================================
// Module      : processor_gen
// Description : Accumulator micro-core with FETCH/EXEC/HALT sequencing, a
//               register file, ALU flags and a bounded call stack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module processor_gen #(
    parameter int DW     = 8,
    parameter int NREG   = 16,
    parameter int PCW    = 8,
    parameter int SDEPTH = 4,
    localparam int RAW   = $clog2(NREG),
    localparam int IW    = 4 + RAW
) (
    input  logic           clk,
    input  logic           CLB,
    input  logic [IW-1:0]  INST,
    input  logic           INST_VALID,
    output logic           INST_REQ,
    output logic [PCW-1:0] PC,
    output logic [DW-1:0]  ACC,
    output logic           Z,
    output logic           C,
    output logic           HALTED,
    output logic           ERR
);

    // Stack pointer counts 0..SDEPTH; the slot array is sized to the pointer
    // range so every pointer value is a legal index.
    localparam int SPW    = $clog2(SDEPTH + 1);
    localparam int SSLOTS = 2 ** SPW;
    localparam logic [SPW-1:0] c_sp_full = SPW'(SDEPTH);

    localparam logic [3:0] c_op_nop = 4'h0;
    localparam logic [3:0] c_op_ldi = 4'h1;
    localparam logic [3:0] c_op_ldr = 4'h2;
    localparam logic [3:0] c_op_str = 4'h3;
    localparam logic [3:0] c_op_add = 4'h4;
    localparam logic [3:0] c_op_sub = 4'h5;
    localparam logic [3:0] c_op_and = 4'h6;
    localparam logic [3:0] c_op_or  = 4'h7;
    localparam logic [3:0] c_op_xor = 4'h8;
    localparam logic [3:0] c_op_shl = 4'h9;
    localparam logic [3:0] c_op_shr = 4'hA;
    localparam logic [3:0] c_op_jmp = 4'hB;
    localparam logic [3:0] c_op_jz  = 4'hC;
    localparam logic [3:0] c_op_jc  = 4'hD;
    localparam logic [3:0] c_op_cal = 4'hE;
    localparam logic [3:0] c_op_sys = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [DW-1:0]  acc_q, acc_d;
    logic           z_q, z_d;
    logic           c_q, c_d;
    logic           err_q, err_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic [IW-1:0]  ir_q, ir_d;
    logic [DW-1:0]  regs_q  [NREG];
    logic [DW-1:0]  regs_d  [NREG];
    logic [PCW-1:0] stack_q [SSLOTS];
    logic [PCW-1:0] stack_d [SSLOTS];

    logic [3:0]     w_opc;
    logic [RAW-1:0] w_op;
    logic [DW-1:0]  w_rdata;
    logic [DW-1:0]  w_imm;
    logic [PCW-1:0] w_tgt;
    logic [PCW-1:0] w_pc_inc;
    logic [DW:0]    w_sum;
    logic [DW:0]    w_diff;
    logic           w_upd_z;

    assign w_opc    = ir_q[IW-1:RAW];
    assign w_op     = ir_q[RAW-1:0];
    assign w_rdata  = regs_q[w_op];
    assign w_imm    = DW'(w_op);
    assign w_tgt    = PCW'(w_rdata);
    assign w_pc_inc = pc_q + PCW'(1);
    assign w_sum    = {1'b0, acc_q} + {1'b0, w_rdata};
    // Top bit of the extended difference is the unsigned borrow.
    assign w_diff   = {1'b0, acc_q} - {1'b0, w_rdata};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        z_d     = z_q;
        c_d     = c_q;
        err_d   = err_q;
        sp_d    = sp_q;
        ir_d    = ir_q;
        regs_d  = regs_q;
        stack_d = stack_q;
        w_upd_z = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (INST_VALID) begin
                    ir_d    = INST;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = w_pc_inc;
                case (w_opc)
                    c_op_nop: ;
                    c_op_ldi: begin acc_d = w_imm;   w_upd_z = 1'b1; end
                    c_op_ldr: begin acc_d = w_rdata; w_upd_z = 1'b1; end
                    c_op_str: regs_d[w_op] = acc_q;
                    c_op_add: begin {c_d, acc_d} = w_sum; w_upd_z = 1'b1; end
                    c_op_sub: begin
                        acc_d   = w_diff[DW-1:0];
                        c_d     = w_diff[DW];
                        w_upd_z = 1'b1;
                    end
                    c_op_and: begin acc_d = acc_q & w_rdata; w_upd_z = 1'b1; end
                    c_op_or:  begin acc_d = acc_q | w_rdata; w_upd_z = 1'b1; end
                    c_op_xor: begin acc_d = acc_q ^ w_rdata; w_upd_z = 1'b1; end
                    c_op_shl: begin
                        c_d     = acc_q[DW-1];
                        acc_d   = {acc_q[DW-2:0], 1'b0};
                        w_upd_z = 1'b1;
                    end
                    c_op_shr: begin
                        c_d     = acc_q[0];
                        acc_d   = {1'b0, acc_q[DW-1:1]};
                        w_upd_z = 1'b1;
                    end
                    c_op_jmp: pc_d = w_tgt;
                    c_op_jz:  if (z_q) pc_d = w_tgt;
                    c_op_jc:  if (c_q) pc_d = w_tgt;
                    c_op_cal: begin
                        if (sp_q == c_sp_full) begin
                            err_d = 1'b1;
                        end else begin
                            stack_d[sp_q] = w_pc_inc;
                            sp_d          = sp_q + SPW'(1);
                            pc_d          = w_tgt;
                        end
                    end
                    c_op_sys: begin
                        if (w_op != '0) begin
                            pc_d    = pc_q;
                            state_d = S_HALT;
                        end else if (sp_q == '0) begin
                            err_d = 1'b1;
                        end else begin
                            pc_d = stack_q[sp_q - SPW'(1)];
                            sp_d = sp_q - SPW'(1);
                        end
                    end
                    default: ;
                endcase
                if (w_upd_z) begin
                    z_d = (acc_d == '0);
                end
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (CLB) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            acc_q   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            err_q   <= 1'b0;
            sp_q    <= '0;
            ir_q    <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            for (int i = 0; i < SSLOTS; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
            c_q     <= c_d;
            err_q   <= err_d;
            sp_q    <= sp_d;
            ir_q    <= ir_d;
            regs_q  <= regs_d;
            stack_q <= stack_d;
        end
    end

    assign INST_REQ = (state_q == S_FETCH);
    assign HALTED   = (state_q == S_HALT);
    assign PC       = pc_q;
    assign ACC      = acc_q;
    assign Z        = z_q;
    assign C        = c_q;
    assign ERR      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_processor_gen.sv
// ============================================================================
// Module      : tb_processor_gen
// Description : Directed plus randomized checks of processor_gen against an
//               instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_processor_gen;

    localparam int SD = 2;

    logic       clk = 1'b0;
    logic       CLB;
    logic [7:0] INST;
    logic       INST_VALID;
    logic       INST_REQ, Z, C, HALTED, ERR;
    logic [7:0] PC, ACC;

    logic [5:0]  INST2;
    logic        INST_VALID2;
    logic        INST_REQ2, Z2, C2, HALTED2, ERR2;
    logic [9:0]  PC2;
    logic [15:0] ACC2;

    always #5 clk = ~clk;

    processor_gen #(.DW(8), .NREG(16), .PCW(8), .SDEPTH(SD)) dut (
        .clk(clk), .CLB(CLB), .INST(INST), .INST_VALID(INST_VALID),
        .INST_REQ(INST_REQ), .PC(PC), .ACC(ACC), .Z(Z), .C(C),
        .HALTED(HALTED), .ERR(ERR)
    );

    processor_gen #(.DW(16), .NREG(4), .PCW(10), .SDEPTH(SD)) dut2 (
        .clk(clk), .CLB(CLB), .INST(INST2), .INST_VALID(INST_VALID2),
        .INST_REQ(INST_REQ2), .PC(PC2), .ACC(ACC2), .Z(Z2), .C(C2),
        .HALTED(HALTED2), .ERR(ERR2)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Instruction-level model of the 8-bit configuration
    int m_pc, m_acc, m_z, m_c, m_err, m_halt;
    int m_regs [16];
    int m_stack[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc = 0; m_acc = 0; m_z = 0; m_c = 0; m_err = 0; m_halt = 0;
        for (int i = 0; i < 16; i++) m_regs[i] = 0;
        m_stack.delete();
    endtask

    task automatic model_exec(input int inst);
        int opc, op, r, s, nxt;
        opc = inst / 16;
        op  = inst % 16;
        r   = m_regs[op];
        nxt = (m_pc + 1) % 256;
        case (opc)
            1:  m_acc = op;
            2:  m_acc = r;
            3:  m_regs[op] = m_acc;
            4:  begin s = m_acc + r; m_c = (s > 255); m_acc = s % 256; end
            5:  begin m_c = (m_acc < r); m_acc = (m_acc - r + 256) % 256; end
            6:  m_acc = m_acc & r;
            7:  m_acc = m_acc | r;
            8:  m_acc = m_acc ^ r;
            9:  begin m_c = (m_acc >= 128); m_acc = (m_acc * 2) % 256; end
            10: begin m_c = m_acc % 2; m_acc = m_acc / 2; end
            11: nxt = r;
            12: if (m_z == 1) nxt = r;
            13: if (m_c == 1) nxt = r;
            14: begin
                if (m_stack.size() == SD) m_err = 1;
                else begin m_stack.push_back(nxt); nxt = r; end
            end
            15: begin
                if (op != 0) begin m_halt = 1; nxt = m_pc; end
                else if (m_stack.size() == 0) m_err = 1;
                else nxt = m_stack.pop_back();
            end
            default: ;
        endcase
        if (opc == 1 || opc == 2 || (opc >= 4 && opc <= 10)) m_z = (m_acc == 0);
        m_pc = nxt;
    endtask

    task automatic check_state(input string name);
        chk({name, "_pc"},   PC,       m_pc);
        chk({name, "_acc"},  ACC,      m_acc);
        chk({name, "_z"},    Z,        m_z);
        chk({name, "_c"},    C,        m_c);
        chk({name, "_err"},  ERR,      m_err);
        chk({name, "_halt"}, HALTED,   m_halt);
        chk({name, "_req"},  INST_REQ, (m_halt == 0));
    endtask

    task automatic issue(input logic [7:0] inst, input string name);
        INST = inst; INST_VALID = 1'b1;
        @(posedge clk); #1;
        INST_VALID = 1'b0; INST = 8'h00;
        @(posedge clk); #1;
        model_exec(int'(inst));
        check_state(name);
    endtask

    task automatic issue2(input logic [5:0] inst);
        INST2 = inst; INST_VALID2 = 1'b1;
        @(posedge clk); #1;
        INST_VALID2 = 1'b0; INST2 = 6'h00;
        @(posedge clk); #1;
    endtask

    // Reset with a fetch pending, which must be discarded
    task automatic do_reset();
        CLB = 1'b1; INST = 8'h1F; INST_VALID = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        CLB = 1'b0; INST_VALID = 1'b0; INST = 8'h00;
        model_reset();
    endtask

    initial begin
        int p, opc, op;
        logic [7:0] ri;
        CLB = 1'b0; INST = 8'h00; INST_VALID = 1'b0;
        INST2 = 6'h00; INST_VALID2 = 1'b0;
        @(posedge clk); #1;

        do_reset();
        check_state("rst");

        // Load/store/add sequence
        issue(8'h15, "ldi5");
        issue(8'h33, "str3");
        issue(8'h10, "ldi0");
        issue(8'h43, "add3");
        chk("seq_acc", ACC, 8'd5);
        chk("seq_pc",  PC,  8'd4);

        // Build 0xFF, then carry-out and borrow cases
        issue(8'h11, "ldi1");
        issue(8'h31, "str1");
        issue(8'h10, "ldi0b");
        issue(8'h51, "sub_to_ff");
        chk("ff_acc", ACC, 8'hFF);
        issue(8'h41, "add_wrap");
        chk("addwrap_acc", ACC, 8'h00);
        chk("addwrap_z",   Z,   1'b1);
        chk("addwrap_c",   C,   1'b1);
        issue(8'h51, "sub_borrow");
        chk("borrow_acc", ACC, 8'hFF);
        chk("borrow_c",   C,   1'b1);

        // Fetch stall: nothing moves while INST_VALID is low
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_req", INST_REQ, 1'b1);
            chk("stall_pc",  PC,  m_pc);
            chk("stall_acc", ACC, m_acc);
            chk("stall_c",   C,   m_c);
        end
        issue(8'h12, "after_stall");

        // Call stack: two pushes fit, the third overflows
        issue(8'h19, "ldi9");
        issue(8'h32, "str2");
        p = m_pc;
        issue(8'hE2, "call1");
        issue(8'hE2, "call2");
        issue(8'hE2, "call3");
        chk("call3_err", ERR, 1'b1);
        chk("call3_pc",  PC,  8'd10);
        issue(8'hF0, "ret1");
        chk("ret1_pc", PC, 8'd10);
        issue(8'hF0, "ret2");
        chk("ret2_pc", PC, p + 1);
        issue(8'hF0, "ret_empty");
        chk("retempty_err", ERR, 1'b1);
        chk("retempty_pc",  PC,  p + 2);

        // Reset while a JMP is in EXEC
        INST = 8'hB2; INST_VALID = 1'b1;
        @(posedge clk); #1;
        INST_VALID = 1'b0; CLB = 1'b1;
        @(posedge clk); #1;
        CLB = 1'b0;
        model_reset();
        check_state("rst_exec");
        issue(8'h22, "regs_cleared");

        // HALT holds until reset
        issue(8'h00, "nop");
        issue(8'hF1, "halt");
        repeat (3) @(posedge clk);
        #1;
        check_state("halt_hold");
        do_reset();
        check_state("halt_rst");

        // Randomized instruction stream with occasional fetch stalls
        for (int k = 0; k < 200; k++) begin
            opc = $urandom_range(0, 14);
            op  = $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0) begin opc = 15; op = 0; end
            ri = 8'((opc * 16) + op);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            issue(ri, "rnd");
        end
        issue(8'hF3, "rnd_halt");

        // Wide configuration: wrap and zero-extended jump target
        do_reset();
        issue2(6'h05);
        issue2(6'h0D);
        issue2(6'h04);
        issue2(6'h15);
        chk("w16_acc", ACC2, 16'hFFFF);
        chk("w16_c",   C2,   1'b1);
        issue2(6'h0C);
        issue2(6'h2C);
        chk("w16_jmp_pc", PC2, 10'h3FF);
        issue2(6'h00);
        chk("w16_wrap_pc", PC2, 10'h000);
        chk("w16_req",     INST_REQ2, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/processor_gen.md
PROCESSOR_GEN -- requirements
Module: processor_gen

Interface
REQ-001 Parameter DW, default 8: datapath width for the accumulator, registers and ALU; legal range 4..32.
REQ-002 Parameter NREG, default 16: register-file depth; power of two, 2..256; RAW = log2(NREG).
REQ-003 Parameter PCW, default 8: program-counter width; legal range 4..16.
REQ-004 Parameter SDEPTH, default 4: call-stack depth; legal range 1..16.
REQ-005 Derived IW = 4 + RAW: instruction width, with opcode in INST[IW-1:RAW] and operand OP in INST[RAW-1:0].
REQ-006 Port clk, input, 1: the single clock; one clock, all state updates on its rising edge.
REQ-007 Port CLB, input, 1: reset; reset is synchronous and active-high.
REQ-008 Port INST, input, IW: instruction word for address PC.
REQ-009 Port INST_VALID, input, 1: INST is valid this cycle.
REQ-010 Port INST_REQ, output, 1: core is in FETCH and requests the instruction at PC.
REQ-011 Port PC, output, PCW: current fetch address.
REQ-012 Port ACC, output, DW: accumulator contents.
REQ-013 Port Z, output, 1: registered zero flag.
REQ-014 Port C, output, 1: registered carry/borrow flag.
REQ-015 Port HALTED, output, 1: core is in the HALT state.
REQ-016 Port ERR, output, 1: sticky stack error.

Function
REQ-017 The FSM SHALL have three states: FETCH, EXEC and HALT; INST_REQ = 1 only in FETCH.
REQ-018 In FETCH, on INST_VALID = 1 the core SHALL latch INST into an internal IR and go to EXEC.
REQ-019 In FETCH with INST_VALID = 0 the core SHALL stay in FETCH with all architectural state held.
REQ-020 EXEC SHALL last exactly one cycle and then return to FETCH, except for HALT; minimum throughput is 2 cycles per instruction.
REQ-021 The default next PC after EXEC SHALL be PC+1, computed modulo 2^PCW (wraps from all-ones to 0).
REQ-022 Immediate IMM = OP zero-extended (or truncated) to DW; R[OP] is register-file entry OP.
REQ-023 Opcode 0 NOP: no state change other than PC+1.
REQ-024 Opcode 1 LDI: ACC = IMM. Opcode 2 LDR: ACC = R[OP]. Both update Z; C is unchanged.
REQ-025 Opcode 3 STR: R[OP] = ACC; flags are unchanged.
REQ-026 Opcode 4 ADD: {C,ACC} = ACC + R[OP], DW+1 bits. Opcode 5 SUB: ACC = ACC - R[OP], C = 1 on borrow (ACC < R[OP], unsigned).
REQ-027 Opcodes 6/7/8 AND/OR/XOR with R[OP]: C is unchanged.
REQ-028 Opcode 9 SHL: C = ACC[DW-1], ACC = ACC << 1. Opcode A SHR: C = ACC[0], ACC = ACC >> 1 (logical).
REQ-029 Opcodes 1, 2 and 4 through A SHALL set Z = (new ACC == 0).
REQ-030 Opcode B JMP: PC = R[OP][PCW-1:0], with R[OP] zero-extended if DW < PCW.
REQ-031 Opcode C JZ / D JC: jump as JMP if Z / C is 1 at EXEC entry, else PC+1.
REQ-032 Opcode E CALL: push PC+1 and jump as JMP.
REQ-033 CALL with the stack full: no push, ERR is set, PC = PC+1 (the instruction executes as NOP).
REQ-034 Opcode F with OP = 0, RET: pop into PC. RET with the stack empty: ERR is set, PC = PC+1.
REQ-035 Opcode F with OP != 0, HALT: the core enters HALT with PC unchanged and stays there until CLB.
REQ-036 ERR SHALL stay at 1 until CLB.
REQ-037 The register file SHALL be synchronous-write with a combinational read; STR followed immediately by LDR of the same entry returns the new value.

Reset
REQ-038 CLB = 1 at a rising edge SHALL clear, in any state and mid-instruction: PC = 0, ACC = 0, Z = 0, C = 0, ERR = 0, stack pointer = 0 (empty), IR = 0.
REQ-039 Reset SHALL also set state = FETCH, so INST_REQ = 1 in the first cycle after reset release.
REQ-040 Reset SHALL clear all NREG registers to 0.
REQ-041 A pending un-acknowledged fetch SHALL be discarded by reset.

Verification
REQ-042 Defaults: LDI 5; STR 3; LDI 0; ADD 3 -> ACC = 5, Z = 0, C = 0, PC = 4 after 8 INST_VALID-always cycles.
REQ-043 ACC = 0xFF, R1 = 0x01, ADD 1 -> ACC = 0x00, Z = 1, C = 1; then SUB 1 -> ACC = 0xFF, C = 1.
REQ-044 SDEPTH = 2: execute three CALLs -> the third gives ERR = 1, PC = its address + 1; RETs return in LIFO order; a RET on the empty stack leaves ERR = 1.
REQ-045 Hold INST_VALID = 0 for 5 cycles in FETCH -> PC, ACC and flags are unchanged and INST_REQ stays 1; the instruction completes when valid is asserted.
REQ-046 Assert CLB during EXEC of a JMP -> next cycle PC = 0, ACC = 0, state FETCH; HALT followed by CLB -> HALTED = 0.
REQ-047 DW = 16, NREG = 4, PCW = 10: PC wraps from 0x3FF to 0x000 on NOP; JMP with R0 = 0xFFFF -> PC = 0x3FF.
